// File: rtl/tilt_pkg.sv
// Shared definitions for the tilt-correction frame sequencer:
// default frame geometry, derived Sobel grid size, coordinate widths, phase codes.
package tilt_pkg;

  localparam int IMG_W_DEF     = 80;
  localparam int IMG_H_DEF     = 40;
  localparam int SOBEL_LAT_DEF = 3;
  localparam int ANGLE_TO_DEF  = 64;

  localparam int KW_DEF = IMG_W_DEF - 2;
  localparam int KH_DEF = IMG_H_DEF - 2;

  localparam int XW_DEF = $clog2(IMG_W_DEF);
  localparam int YW_DEF = $clog2(IMG_H_DEF);

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_LOAD   = 3'd1,
    PH_FLUSH  = 3'd2,
    PH_BW     = 3'd3,
    PH_SEARCH = 3'd4,
    PH_ANGLE  = 3'd5,
    PH_DONE   = 3'd6
  } phase_e;

  // Width of a counter that must hold 0..n-1, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tilt_tag_delay.sv
// Window-coordinate tag delay line: a DEPTH-deep shift of {v,x,y} that advances
// only on i_ce, so tags stay aligned with the Sobel window through input stalls.
// Ports: clk, rst (async high), i_clr (sync clear), i_ce, i_v/i_x/i_y in, o_v/o_x/o_y out.
module tilt_tag_delay
  import tilt_pkg::*;
#(
  parameter int DEPTH = SOBEL_LAT_DEF,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_ce,
  input  logic          i_v,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  output logic          o_v,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y
);

  localparam int TW = 1 + XW + YW;

  logic [TW-1:0] r_line [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
    end else if (i_ce) begin
      r_line[0] <= {i_v, i_x, i_y};
      for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
    end
  end

  assign {o_v, o_x, o_y} = r_line[DEPTH-1];

endmodule

// File: rtl/tilt_frame_sequencer.sv
// Frame sequencer for the tilt-correction pipeline: pixel load with Sobel write tags,
// flush, BW and corner-search raster scans, CORDIC trigger/timeout, angle latch.
// Ports: clk/rst, start/abort control, in_valid/in_ready stream, stream_ce and
// sob_we/sob_x/sob_y to the Sobel grid, scan_* raster, cordic handshake, status.
module tilt_frame_sequencer
  import tilt_pkg::*;
#(
  parameter  int IMG_W     = IMG_W_DEF,
  parameter  int IMG_H     = IMG_H_DEF,
  parameter  int SOBEL_LAT = SOBEL_LAT_DEF,
  parameter  int ANGLE_TO  = ANGLE_TO_DEF,
  localparam int XW        = $clog2(IMG_W),
  localparam int YW        = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          stream_ce,
  output logic          sob_we,
  output logic [XW-1:0] sob_x,
  output logic [YW-1:0] sob_y,
  output logic [2:0]    phase,
  output logic          scan_valid,
  output logic [XW-1:0] scan_x,
  output logic [YW-1:0] scan_y,
  output logic          cordic_start,
  input  logic          cordic_done,
  input  logic [31:0]   degree_in,
  output logic [31:0]   degree_out,
  output logic          done,
  output logic          timeout,
  output logic          busy
);

  localparam int CMAX = (ANGLE_TO > SOBEL_LAT) ? ANGLE_TO : SOBEL_LAT;
  localparam int CW   = cnt_w(CMAX);

  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [XW-1:0] X_TWO   = XW'(2);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_KLAST = XW'(IMG_W - 3);
  localparam logic [XW-1:0] X_SLAST = XW'(IMG_W - 4);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [YW-1:0] Y_TWO   = YW'(2);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_KLAST = YW'(IMG_H - 3);
  localparam logic [CW-1:0] C_FLUSH = CW'(SOBEL_LAT - 1);
  localparam logic [CW-1:0] C_TO    = CW'(ANGLE_TO - 1);

  phase_e        r_state;
  phase_e        w_state_nxt;
  logic [XW-1:0] r_x;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] r_y;
  logic [YW-1:0] w_y_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_timeout;
  logic          w_to_nxt;
  logic [31:0]   r_deg;
  logic [31:0]   w_deg_nxt;

  logic          w_tag_ok;
  logic          w_push_v;
  logic [XW-1:0] w_push_x;
  logic [YW-1:0] w_push_y;
  logic          w_tag_v;

  // A pixel completes a 3x3 window once it is at least two in from the top-left.
  assign w_tag_ok = (r_x >= X_TWO) && (r_y >= Y_TWO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= PH_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_deg     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_to_nxt;
      r_deg     <= w_deg_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_cnt_nxt    = r_cnt;
    w_to_nxt     = r_timeout;
    w_deg_nxt    = r_deg;
    w_push_v     = 1'b0;
    w_push_x     = '0;
    w_push_y     = '0;
    in_ready     = 1'b0;
    stream_ce    = 1'b0;
    scan_valid   = 1'b0;
    cordic_start = 1'b0;
    done         = 1'b0;

    unique case (r_state)
      PH_IDLE: begin
        if (start) begin
          w_state_nxt = PH_LOAD;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_to_nxt    = 1'b0;
        end
      end

      PH_LOAD: begin
        in_ready  = 1'b1;
        stream_ce = in_valid;
        w_push_v  = w_tag_ok;
        w_push_x  = w_tag_ok ? (r_x - X_TWO) : '0;
        w_push_y  = w_tag_ok ? (r_y - Y_TWO) : '0;
        if (in_valid) begin
          if (r_x == X_LAST) begin
            w_x_nxt = '0;
            if (r_y == Y_LAST) begin
              w_y_nxt     = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = PH_FLUSH;
            end else begin
              w_y_nxt = r_y + 1'b1;
            end
          end else begin
            w_x_nxt = r_x + 1'b1;
          end
        end
      end

      // Push empty tags so the last real windows drain out of the Sobel pipe.
      PH_FLUSH: begin
        stream_ce = 1'b1;
        if (r_cnt == C_FLUSH) begin
          w_cnt_nxt   = '0;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_state_nxt = PH_BW;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      PH_BW: begin
        scan_valid = 1'b1;
        if (r_x == X_KLAST) begin
          w_x_nxt = '0;
          if (r_y == Y_KLAST) begin
            w_x_nxt     = X_ONE;
            w_y_nxt     = Y_ONE;
            w_state_nxt = PH_SEARCH;
          end else begin
            w_y_nxt = r_y + 1'b1;
          end
        end else begin
          w_x_nxt = r_x + 1'b1;
        end
      end

      // Corner search skips the outer border columns and the top row.
      PH_SEARCH: begin
        scan_valid = 1'b1;
        if (r_x == X_SLAST) begin
          w_x_nxt = X_ONE;
          if (r_y == Y_KLAST) begin
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = PH_ANGLE;
          end else begin
            w_y_nxt = r_y + 1'b1;
          end
        end else begin
          w_x_nxt = r_x + 1'b1;
        end
      end

      // The wait counter is zero only on the first ANGLE cycle.
      PH_ANGLE: begin
        cordic_start = (r_cnt == '0);
        if (cordic_done) begin
          w_deg_nxt   = degree_in;
          w_cnt_nxt   = '0;
          w_state_nxt = PH_DONE;
        end else if (r_cnt == C_TO) begin
          w_to_nxt    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = PH_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      PH_DONE: begin
        done        = 1'b1;
        w_state_nxt = PH_IDLE;
      end

      default: begin
        w_state_nxt = PH_IDLE;
      end
    endcase

    // Abort leaves the latched angle and timeout flag as they were.
    if (abort) begin
      w_state_nxt = PH_IDLE;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_cnt_nxt   = '0;
      w_to_nxt    = r_timeout;
      w_deg_nxt   = r_deg;
    end
  end

  // Abort also empties the tag line so no stale window leaks into the next frame.
  tilt_tag_delay #(
    .DEPTH (SOBEL_LAT),
    .XW    (XW),
    .YW    (YW)
  ) u_tag (
    .clk   (clk),
    .rst   (rst),
    .i_clr (abort),
    .i_ce  (stream_ce),
    .i_v   (w_push_v),
    .i_x   (w_push_x),
    .i_y   (w_push_y),
    .o_v   (w_tag_v),
    .o_x   (sob_x),
    .o_y   (sob_y)
  );

  assign sob_we     = w_tag_v & stream_ce;
  assign phase      = r_state;
  assign busy       = (r_state != PH_IDLE);
  assign scan_x     = scan_valid ? r_x : '0;
  assign scan_y     = scan_valid ? r_y : '0;
  assign degree_out = r_deg;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_tilt_frame_sequencer.sv
// Self-checking bench for tilt_frame_sequencer: table of frame scenarios plus
// hand-written abort and mid-scan reset sequences.
module tb_tilt_frame_sequencer;

  localparam int KW = 78;
  localparam int KH = 38;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        cordic_done = 1'b0;
  logic [31:0] degree_in = '0;
  logic        in_ready, stream_ce, sob_we, scan_valid;
  logic        cordic_start, done, timeout, busy;
  logic [6:0]  sob_x, scan_x;
  logic [5:0]  sob_y, scan_y;
  logic [2:0]  phase;
  logic [31:0] degree_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tilt_frame_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .stream_ce    (stream_ce),
    .sob_we       (sob_we),
    .sob_x        (sob_x),
    .sob_y        (sob_y),
    .phase        (phase),
    .scan_valid   (scan_valid),
    .scan_x       (scan_x),
    .scan_y       (scan_y),
    .cordic_start (cordic_start),
    .cordic_done  (cordic_done),
    .degree_in    (degree_in),
    .degree_out   (degree_out),
    .done         (done),
    .timeout      (timeout),
    .busy         (busy)
  );

  // Per-frame monitor, cleared when frame_id changes.
  int frame_id = 0;
  int seen_id = 0;
  int m_rdy, m_acc, m_flush, m_we, m_tag_err, m_ce_err;
  int m_bw, m_sr, m_scan_err, m_ang, m_done;
  int e_sx, e_sy, bx, by, sx, sy;
  int last_x, last_y, last_ph;

  always @(negedge clk) begin
    if (seen_id != frame_id) begin
      seen_id = frame_id;
      m_rdy = 0; m_acc = 0; m_flush = 0; m_we = 0;
      m_tag_err = 0; m_ce_err = 0; m_bw = 0; m_sr = 0;
      m_scan_err = 0; m_ang = 0; m_done = 0;
      e_sx = 0; e_sy = 0; bx = 0; by = 0; sx = 1; sy = 1;
      last_x = -1; last_y = -1; last_ph = -1;
    end else if (!rst) begin
      if (in_ready) begin
        m_rdy++;
        if (phase != 3'd1) m_ce_err++;
      end
      if (in_valid && in_ready) m_acc++;
      if (phase == 3'd1 && stream_ce && !in_valid) m_ce_err++;
      if (phase == 3'd2 && stream_ce) m_flush++;
      if (sob_we) begin
        if (!stream_ce) m_ce_err++;
        if (int'(sob_x) != e_sx || int'(sob_y) != e_sy) m_tag_err++;
        m_we++;
        last_x = int'(sob_x); last_y = int'(sob_y); last_ph = int'(phase);
        if (e_sx == KW - 1) begin e_sx = 0; e_sy++; end
        else e_sx++;
      end
      if (phase == 3'd3) begin
        m_bw++;
        if (!scan_valid || int'(scan_x) != bx || int'(scan_y) != by) m_scan_err++;
        if (bx == KW - 1) begin bx = 0; by++; end
        else bx++;
      end else if (phase == 3'd4) begin
        m_sr++;
        if (!scan_valid || int'(scan_x) != sx || int'(scan_y) != sy) m_scan_err++;
        if (sx == KW - 2) begin sx = 1; sy++; end
        else sx++;
      end else if (scan_valid) begin
        m_scan_err++;
      end
      if (phase == 3'd5) m_ang++;
      if (done) m_done++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    frame_id++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_load(input int duty, input int abort_at, output bit aborted);
    int cyc = 0;
    int acc = 0;
    aborted = 1'b0;
    while (phase == 3'd1 && cyc < 40000) begin
      if (abort_at >= 0 && acc == abort_at) begin
        abort = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        aborted = 1'b1;
        break;
      end
      in_valid = ((cyc % duty) == 0);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] ph, output bit ok);
    int n = 0;
    while (phase !== ph && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (phase === ph);
  endtask

  task automatic run_frame(input int duty, input int cdelay, input logic [31:0] deg,
                           input logic [31:0] exp_deg, input logic exp_to, input int exp_ang);
    bit ab;
    bit ok;
    do_start();
    chk("load_entry", {phase, busy, in_ready}, {3'd1, 1'b1, 1'b1});
    drive_load(duty, -1, ab);
    wait_phase(3'd3, ok);
    chk("bw_reached", ok, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_bw", phase, 3'd3);
    degree_in = (cdelay < 0) ? deg : ~deg;
    wait_phase(3'd5, ok);
    chk("angle_reached", ok, 1);
    chk("cstart_first", cordic_start, 1);
    if (cdelay < 0) begin
      wait_phase(3'd6, ok);
      chk("done_reached", ok, 1);
    end else begin
      for (int k = 0; k < cdelay; k++) begin
        @(posedge clk); #1;
        if (k == 0) chk("cstart_once", cordic_start, 0);
      end
      cordic_done = 1'b1;
      degree_in = deg;
      @(posedge clk); #1;
      cordic_done = 1'b0;
      degree_in = ~deg;
    end
    chk("done_state", {phase, done}, {3'd6, 1'b1});
    chk("degree_out", degree_out, exp_deg);
    chk("timeout", timeout, exp_to);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_to_idle", {phase, done, busy}, 0);
    chk("deg_hold", degree_out, exp_deg);
    chk("to_sticky", timeout, exp_to);
    chk("accepts", m_acc, 3200);
    chk("ready_cycles", m_rdy, 3199 * duty + 1);
    chk("sob_we_count", m_we, KW * KH);
    chk("tag_order_err", m_tag_err, 0);
    chk("ce_err", m_ce_err, 0);
    chk("last_tag", {last_x[7:0], last_y[7:0], last_ph[7:0]}, {8'd77, 8'd37, 8'd2});
    chk("flush_cycles", m_flush, 3);
    chk("bw_cycles", m_bw, KW * KH);
    chk("search_cycles", m_sr, (KW - 2) * (KH - 1));
    chk("scan_err", m_scan_err, 0);
    chk("angle_cycles", m_ang, exp_ang);
    chk("done_pulses", m_done, 1);
  endtask

  typedef struct {
    int          duty;
    int          cdelay;
    logic [31:0] deg;
    logic [31:0] exp_deg;
    logic        exp_to;
    int          exp_ang;
  } vec_t;

  vec_t tbl [4];

  initial begin
    bit ab;
    bit ok;
    tbl[0] = '{1, 10, 32'h0000_0A80, 32'h0000_0A80, 1'b0, 11};
    tbl[1] = '{3, -1, 32'h0000_DEAD, 32'h0000_0A80, 1'b1, 64};
    tbl[2] = '{2,  0, 32'hFFFF_F600, 32'hFFFF_F600, 1'b0, 1};
    tbl[3] = '{1, 63, 32'h0000_1234, 32'h0000_1234, 1'b0, 64};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {in_ready, stream_ce, sob_we, sob_x, sob_y, phase, scan_valid,
                      scan_x, scan_y, cordic_start, done, timeout, busy}, 0);
    chk("reset_deg", degree_out, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].duty, tbl[i].cdelay, tbl[i].deg,
                tbl[i].exp_deg, tbl[i].exp_to, tbl[i].exp_ang);
    end

    // Abort part-way through LOAD, then a clean frame.
    do_start();
    drive_load(1, 1000, ab);
    chk("abort_taken", ab, 1);
    chk("abort_idle", {phase, busy, in_ready, stream_ce, scan_valid}, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_no_done", m_done, 0);
    chk("abort_accepts", m_acc, 1000);
    chk("abort_deg_kept", degree_out, 32'h0000_1234);
    run_frame(1, 10, 32'h0000_0A80, 32'h0000_0A80, 1'b0, 11);

    // Asynchronous reset in the middle of the BW scan.
    do_start();
    drive_load(1, -1, ab);
    wait_phase(3'd3, ok);
    chk("rst_bw_reached", ok, 1);
    repeat (100) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("midrst_ctl", {in_ready, stream_ce, sob_we, sob_x, sob_y, phase, scan_valid,
                       scan_x, scan_y, cordic_start, done, timeout, busy}, 0);
    chk("midrst_deg", degree_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {phase, busy, in_ready}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
